// File: rtl/row_scan_sequencer_if.sv
// rtl/row_scan_sequencer_if.sv - scan request and decoder drive bundle for the row scan sequencer
interface row_scan_sequencer_if;
    logic       run;
    logic [7:0] mask;
    logic [2:0] a;
    logic       en;
    logic       frame_start;
    logic       busy;

    modport master (
        output run,
        output mask,
        input  a,
        input  en,
        input  frame_start,
        input  busy
    );

    modport slave (
        input  run,
        input  mask,
        output a,
        output en,
        output frame_start,
        output busy
    );
endinterface

// File: rtl/row_scan_sequencer.sv
// rtl/row_scan_sequencer.sv - steps a 3-to-8 decoder through masked rows with dwell and blanking
module row_scan_sequencer #(
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    row_scan_sequencer_if.slave  bus
);
    localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DRIVE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    a_q;
    logic          en_q;
    logic          frame_start_q;
    logic          busy_q;
    logic          new_frame_q;

    logic [2:0]    first_row;
    logic [2:0]    above_row;
    logic          any_row;
    logic          has_above;
    logic [2:0]    next_row_d;
    logic          wrap_d;

    // Descending scan so the last hit written is the lowest qualifying index.
    always_comb begin
        first_row = '0;
        above_row = '0;
        any_row   = 1'b0;
        has_above = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (bus.mask[i]) begin
                first_row = 3'(i);
                any_row   = 1'b1;
                if (3'(i) > a_q) begin
                    above_row = 3'(i);
                    has_above = 1'b1;
                end
            end
        end
        wrap_d     = !has_above;
        next_row_d = has_above ? above_row : first_row;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            a_q           <= '0;
            en_q          <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            new_frame_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    en_q          <= 1'b0;
                    frame_start_q <= 1'b0;
                    if (bus.run && any_row) begin
                        state_q     <= S_BLANK;
                        a_q         <= first_row;
                        new_frame_q <= 1'b1;
                        cnt_q       <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                S_BLANK: begin
                    if (!bus.run) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (cnt_q == BLANK_LAST) begin
                        state_q       <= S_DRIVE;
                        en_q          <= 1'b1;
                        frame_start_q <= new_frame_q;
                        cnt_q         <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DRIVE: begin
                    frame_start_q <= 1'b0;
                    // A started row always runs its full dwell; run and mask only matter at its end.
                    if (cnt_q == DWELL_LAST) begin
                        en_q  <= 1'b0;
                        cnt_q <= '0;
                        if (bus.run && any_row) begin
                            state_q     <= S_BLANK;
                            a_q         <= next_row_d;
                            new_frame_q <= wrap_d;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.a           = a_q;
    assign bus.en          = en_q;
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_row_scan_sequencer.sv
// tb/tb_row_scan_sequencer.sv - directed self-checking bench for row_scan_sequencer
module tb_row_scan_sequencer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    row_scan_sequencer_if bus ();

    row_scan_sequencer #(.DWELL(4), .BLANK(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [2:0] a, input logic en,
                           input logic fs, input logic busy);
        chk({tag, "_a"}, 32'(bus.a), 32'(a));
        chk({tag, "_en"}, 32'(bus.en), 32'(en));
        chk({tag, "_fs"}, 32'(bus.frame_start), 32'(fs));
        chk({tag, "_busy"}, 32'(bus.busy), 32'(busy));
    endtask

    task automatic drive_row(input string tag, input logic [2:0] row, input logic fs, input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            chk_out(tag, row, 1'b1, fs && (k == 0), 1'b1);
        end
    endtask

    task automatic blank_row(input string tag, input logic [2:0] row);
        tick();
        chk_out(tag, row, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.run = 1'b0;
        bus.mask = 8'h00;
        tick();
        chk_out("reset", 3'd0, 1'b0, 1'b0, 1'b0);

        // Full scan, two frames, then reset while row 3 is driven.
        rst = 1'b0;
        bus.mask = 8'hFF;
        bus.run = 1'b1;
        tick();
        chk_out("full_start", 3'd0, 1'b0, 1'b0, 1'b1);
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 8; r++) begin
                drive_row("full_drv", 3'(r), r == 0, 4);
                blank_row("full_blk", 3'(r + 1));
            end
        end
        drive_row("full_drv", 3'd0, 1'b1, 4);
        blank_row("full_blk", 3'd1);
        drive_row("full_drv", 3'd1, 1'b0, 4);
        blank_row("full_blk", 3'd2);
        drive_row("full_drv", 3'd2, 1'b0, 4);
        blank_row("full_blk", 3'd3);
        drive_row("pre_rst", 3'd3, 1'b0, 1);
        rst = 1'b1;
        tick();
        chk_out("rst_mid", 3'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        bus.run = 1'b0;
        tick();
        tick();
        chk_out("rst_hold", 3'd0, 1'b0, 1'b0, 1'b0);

        // run drops early in row 3: row still completes, a holds.
        bus.run = 1'b1;
        tick();
        chk_out("stopd_start", 3'd0, 1'b0, 1'b0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            drive_row("stopd_drv", 3'(r), r == 0, 4);
            blank_row("stopd_blk", 3'(r + 1));
        end
        drive_row("stopd_r3", 3'd3, 1'b0, 1);
        bus.run = 1'b0;
        drive_row("stopd_r3", 3'd3, 1'b0, 3);
        tick();
        chk_out("stopd_idle", 3'd3, 1'b0, 1'b0, 1'b0);

        // run drops during BLANK: immediate IDLE, no en pulse.
        bus.run = 1'b1;
        tick();
        chk_out("stopb_start", 3'd0, 1'b0, 1'b0, 1'b1);
        drive_row("stopb_drv", 3'd0, 1'b1, 4);
        blank_row("stopb_blk", 3'd1);
        bus.run = 1'b0;
        tick();
        chk_out("stopb_idle", 3'd1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("stopb_hold", 3'd1, 1'b0, 1'b0, 1'b0);

        // Sparse mask 1010_0100, then mask cleared mid-row 7.
        bus.mask = 8'b1010_0100;
        bus.run = 1'b1;
        tick();
        chk_out("sparse_start", 3'd2, 1'b0, 1'b0, 1'b1);
        for (int f = 0; f < 2; f++) begin
            drive_row("sparse_drv2", 3'd2, 1'b1, 4);
            blank_row("sparse_blk5", 3'd5);
            drive_row("sparse_drv5", 3'd5, 1'b0, 4);
            blank_row("sparse_blk7", 3'd7);
            if (f == 0) begin
                drive_row("sparse_drv7", 3'd7, 1'b0, 4);
                blank_row("sparse_blk2", 3'd2);
            end
        end
        drive_row("mask0_drv7", 3'd7, 1'b0, 2);
        bus.mask = 8'h00;
        drive_row("mask0_drv7", 3'd7, 1'b0, 2);
        tick();
        chk_out("mask0_idle", 3'd7, 1'b0, 1'b0, 1'b0);

        // run with empty mask never leaves IDLE.
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out("mask0_run", 3'd7, 1'b0, 1'b0, 1'b0);
        end

        // Single row: every DRIVE period is a new frame.
        bus.mask = 8'h10;
        tick();
        chk_out("single_start", 3'd4, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive_row("single_drv", 3'd4, 1'b1, 4);
            blank_row("single_blk", 3'd4);
        end
        bus.run = 1'b0;
        tick();
        chk_out("single_stop", 3'd4, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/row_scan_sequencer.md
# row_scan_sequencer

Sequential scan controller that sits directly upstream of the 3-to-8 decoder. It drives the decoder's 3-bit select `a` and its enable `en`. It steps through the enabled rows of an 8-row group with a programmable dwell time per row and a blanking gap between rows. Select changes only while `en` is low, so the one-hot decoder outputs never glitch between two rows.

## Interface
- `DWELL`, default 4: cycles `en` is held high per row; legal range ≥1.
- `BLANK`, default 1: cycles `en` is held low before each row; legal range ≥1.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `run`  input  1  level; 1 means scanning is requested.
- `mask`  input  8  row enable; bit i = 1 means row i is included in the scan.
- `a`  output  3  row select to the decoder; registered.
- `en`  output  1  decoder enable; registered.
- `frame_start`  output  1  one-cycle pulse on the first DRIVE cycle of a frame's first row.
- `busy`  output  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: `en`=0.
  - BLANK: `en`=0, `a` already holds the next row.
  - DRIVE: `en`=1.
- Reset: state IDLE, `a`=0, `en`=0, `frame_start`=0, `busy`=0, counters cleared. Reset overrides all other inputs, in every state.
- Row selection:
  - `mask` is sampled only at row-choice points: in IDLE, and on the last DRIVE cycle.
  - Row chosen from IDLE: the lowest set bit of `mask`.
  - Next row: the lowest set bit with index greater than the current `a`.
  - If no such bit exists, wrap to the lowest set bit overall. A wrap starts a new frame.
- Start condition: IDLE → BLANK when `run`=1 and `mask`≠0. `a` loads the chosen row on the same edge.
- If `run`=1 and `mask`=0 in IDLE, the block stays in IDLE.
- BLANK: counts `BLANK` cycles, then moves to DRIVE.
- `run`=0 during any BLANK cycle: go to IDLE on the next edge. `en` stays 0 and `a` holds its value.
- DRIVE: counts `DWELL` cycles. A row is never truncated, even if `run` drops during it.
- On the last DRIVE cycle:
  - If `run`=1 and `mask`≠0: go to BLANK with `a` = next row.
  - Otherwise: go to IDLE. `a` holds its value.
- `frame_start`: set for the first DRIVE cycle of any row chosen from IDLE or by a wrap.
  - With a single bit set in `mask`, every DRIVE period starts a new frame.
- `a` is written only on edges that enter BLANK. Therefore `a` is stable for the whole of every `en`=1 window.
- Counters are sized to max(`DWELL`,`BLANK`) and are cleared on every state entry.

## Timing
- Start latency: `run` is seen high in IDLE at edge t.
  - After edge t: BLANK, `a` = first row.
  - After edge t+`BLANK`: `en`=1 and `frame_start`=1.
- Per-row period: `BLANK`+`DWELL` cycles. Frame period: N·(`BLANK`+`DWELL`), where N = popcount(`mask`).
- `en` rises only with `a` already stable for ≥1 cycle. `en` falls on the same edge that changes `a`; both are registered, so the decoder sees them simultaneously.
- Stop latency:
  - `run` drops during DRIVE: the row finishes, and IDLE follows the final DRIVE edge.
  - `run` drops during BLANK: IDLE one edge later.
- `busy` falls on the same edge that enters IDLE.
- Reset mid-operation: on the edge after `rst`=1, `en`=0, `a`=0, `busy`=0. No partial row completes.

## Test plan
- Reset mid-DRIVE:
  - Stimulus: `rst` pulsed for 1 cycle while `a`=3, `en`=1.
  - Required: next cycle `en`=0, `a`=0, `busy`=0, `frame_start`=0. The block stays in IDLE until `run` is seen again.
- Full scan (`DWELL`=4, `BLANK`=1, `mask`=8'hFF, `run`=1):
  - `a` steps 0,1,…,7,0.
  - `en` is high for 4 cycles and low for 1 cycle per row.
  - `frame_start` pulses every 40 cycles, coinciding with the first `en` cycle of `a`=0.
  - `a` never changes while `en`=1.
- Sparse mask `mask`=8'b1010_0100: `a` sequence is 2,5,7,2,5,7. `frame_start` fires only on row 2. Frame period is 15 cycles.
- Stop behaviour:
  - `run` deasserted on the 2nd DRIVE cycle of row 3: row 3 still gets 4 `en` cycles, then IDLE, `busy`=0.
  - `run` deasserted during BLANK: IDLE next edge, with no `en` pulse.
- Mask edge cases:
  - `mask` changed to 0 mid-DRIVE: the current row completes, then IDLE.
  - `run`=1 with `mask`=0 in IDLE: the block stays in IDLE and `en` stays 0.
  - `mask`=8'h10: `a`=4 constantly, and `frame_start` fires on every DRIVE period.
